// File: rtl/lag_measure.sv
// Lag-test flash receiver: times start trigger to debounced photo-sensor rise, with block averaging.
// Optional running min/max of the measured lag is built when LAG_MINMAX_EN is defined.
module lag_measure #(
    parameter int CLKS_PER_TICK   = 74,
    parameter int TIMEOUT_TICKS   = 500000,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int AVG_LOG2        = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        starttrigger,
    input  logic        sensor,
    output logic        busy,
    output logic        lag_valid,
    output logic [19:0] lag_value,
    output logic        timeout,
    output logic        avg_valid,
    output logic [19:0] avg_value,
    output logic [7:0]  sample_count,
    output logic [19:0] lag_min,
    output logic [19:0] lag_max
);

    localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = 20 + AVG_LOG2;
    localparam int BW = AVG_LOG2 + 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLKS_PER_TICK - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [19:0]   TIMEOUT_LAG = 20'(TIMEOUT_TICKS);
    localparam logic [BW-1:0] BLOCK_LEN   = BW'(1 << AVG_LOG2);

    typedef enum logic [1:0] {IDLE, MEASURE, HOLDOFF} state_t;

    state_t          state_reg, state_next;
    logic            sync1_reg, sync2_reg, level_reg, rise_reg;
    logic [DW-1:0]   db_cnt_reg;
    logic [PW-1:0]   presc_reg;
    logic [19:0]     lag_cnt_reg;
    logic [AW-1:0]   acc_reg;
    logic [BW-1:0]   block_cnt_reg;

    logic            wrap;
    logic [19:0]     lag_plus;
    logic            tick_expired;
    logic            capture;
    logic            expire;
    logic [AW-1:0]   acc_sum;
    logic [AW-1:0]   avg_shift;
    logic [BW-1:0]   block_next;

    // Sensor path: synchronizer, debounce counter, registered rise flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            level_reg  <= 1'b0;
            rise_reg   <= 1'b0;
            db_cnt_reg <= '0;
        end else begin
            sync1_reg <= sensor;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg == level_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                level_reg  <= sync2_reg;
                rise_reg   <= sync2_reg;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    // Lag is taken from the post-increment count so it equals floor(cycles / CLKS_PER_TICK)
    assign wrap         = (presc_reg == PRESC_LAST);
    assign lag_plus     = lag_cnt_reg + {19'd0, wrap};
    assign tick_expired = (lag_plus >= TIMEOUT_LAG);

    always_ff @(posedge clock) begin
        if (!reset_n || state_reg != MEASURE) begin
            presc_reg   <= '0;
            lag_cnt_reg <= '0;
        end else begin
            presc_reg   <= wrap ? '0 : presc_reg + 1'b1;
            lag_cnt_reg <= lag_plus;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (starttrigger) state_next = MEASURE;
            MEASURE: if (rise_reg || tick_expired) state_next = HOLDOFF;
            HOLDOFF: if (!level_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        capture = 1'b0;
        expire  = 1'b0;
        case (state_reg)
            MEASURE: begin
                busy    = 1'b1;
                capture = rise_reg;
                expire  = !rise_reg && tick_expired;
            end
            HOLDOFF: busy = 1'b1;
            default: ;
        endcase
    end

    assign acc_sum    = acc_reg + AW'(lag_plus);
    assign avg_shift  = acc_sum >> AVG_LOG2;
    assign block_next = block_cnt_reg + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lag_valid     <= 1'b0;
            lag_value     <= '0;
            timeout       <= 1'b0;
            avg_valid     <= 1'b0;
            avg_value     <= '0;
            sample_count  <= '0;
            acc_reg       <= '0;
            block_cnt_reg <= '0;
        end else begin
            lag_valid <= capture;
            timeout   <= expire;
            avg_valid <= 1'b0;
            if (capture) begin
                lag_value <= lag_plus;
                if (sample_count != 8'hFF) begin
                    sample_count <= sample_count + 8'd1;
                end
                // The completing sample closes its block; the next block starts empty
                if (block_next == BLOCK_LEN) begin
                    avg_value     <= avg_shift[19:0];
                    avg_valid     <= 1'b1;
                    acc_reg       <= '0;
                    block_cnt_reg <= '0;
                end else begin
                    acc_reg       <= acc_sum;
                    block_cnt_reg <= block_next;
                end
            end
        end
    end

`ifdef LAG_MINMAX_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lag_min <= 20'hFFFFF;
            lag_max <= '0;
        end else if (capture) begin
            if (lag_plus < lag_min) lag_min <= lag_plus;
            if (lag_plus > lag_max) lag_max <= lag_plus;
        end
    end
`else
    assign lag_min = '0;
    assign lag_max = '0;
`endif

endmodule

// File: tb/tb_lag_measure.sv
// Self-checking bench for lag_measure: vector table, hand-written corner sequences, randomized samples vs. model.
module tb_lag_measure;

    localparam int CLKS = 4;
    localparam int DB   = 2;
    localparam int TMO  = 100;
    localparam int AVGL = 2;
    localparam int LAT  = 2 + DB;

    logic        clock = 1'b0;
    logic        reset_n, starttrigger, sensor;
    logic        busy, lag_valid, timeout, avg_valid;
    logic [19:0] lag_value, avg_value, lag_min, lag_max;
    logic [7:0]  sample_count;

    lag_measure #(
        .CLKS_PER_TICK(CLKS), .TIMEOUT_TICKS(TMO),
        .DEBOUNCE_CYCLES(DB), .AVG_LOG2(AVGL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .starttrigger(starttrigger), .sensor(sensor),
        .busy(busy), .lag_valid(lag_valid), .lag_value(lag_value), .timeout(timeout),
        .avg_valid(avg_valid), .avg_value(avg_value), .sample_count(sample_count),
        .lag_min(lag_min), .lag_max(lag_max)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model state: valid lags of the open block, count, last lag, extremes
    int blk[$];
    int model_count, model_last, model_min, model_max;

    typedef struct {
        int d;        // cycle offset at which the raw sensor goes high
        int h;        // cycles the sensor stays high
        int exp_lag;
        int exp_avg;  // -1 when no average is due
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        blk.delete();
        model_count = 0;
        model_last  = 0;
        model_min   = 20'hFFFFF;
        model_max   = 0;
    endtask

    task automatic model_push(input int lag, output int avg);
        int sum;
        avg = -1;
        model_count = (model_count < 255) ? model_count + 1 : 255;
        model_last  = lag;
        if (lag < model_min) model_min = lag;
        if (lag > model_max) model_max = lag;
        blk.push_back(lag);
        if (blk.size() == (1 << AVGL)) begin
            sum = 0;
            foreach (blk[i]) sum += blk[i];
            avg = sum / (1 << AVGL);
            blk.delete();
        end
    endtask

    // One trigger plus sensor stimulus; records every output pulse and when it happened
    task automatic do_sample(input int d, input int h, input int glitch,
                             output int n_lag, output int lag_at, output int lag_val,
                             output int n_to, output int to_at,
                             output int n_avg, output int avg_at, output int avg_val,
                             output int busy_last);
        int len;
        len = ((d + h > TMO * CLKS) ? d + h : TMO * CLKS) + 12;
        n_lag = 0; lag_at = -1; lag_val = -1;
        n_to = 0; to_at = -1;
        n_avg = 0; avg_at = -1; avg_val = -1;
        busy_last = -1;
        starttrigger = 1'b1;
        @(posedge clock); #1;
        starttrigger = 1'b0;
        for (int k = 1; k <= len; k++) begin
            if (d > 0 && k >= d && k < d + h) sensor = 1'b1;
            else if (glitch > 0 && (k % glitch) == 0 && (d == 0 || k < d - 4)) sensor = 1'b1;
            else sensor = 1'b0;
            @(negedge clock);
            if (busy) busy_last = k - 1;
            if (lag_valid) begin n_lag++; lag_at = k - 1; lag_val = int'(lag_value); end
            if (timeout) begin n_to++; to_at = k - 1; end
            if (avg_valid) begin n_avg++; avg_at = k - 1; avg_val = int'(avg_value); end
            @(posedge clock); #1;
        end
        sensor = 1'b0;
    endtask

    task automatic run_checked(input string tag, input int d, input int h, input int glitch);
        int n_lag, lag_at, lag_val, n_to, to_at, n_avg, avg_at, avg_val, busy_last;
        int n, exp_lag, exp_avg;
        do_sample(d, h, glitch, n_lag, lag_at, lag_val, n_to, to_at,
                  n_avg, avg_at, avg_val, busy_last);
        if (d > 0) begin
            n = d + LAT;
            exp_lag = n / CLKS;
            model_push(exp_lag, exp_avg);
            check({tag, " lag_pulses"}, n_lag, 1);
            check({tag, " lag_value"}, lag_val, exp_lag);
            check({tag, " lag_time"}, lag_at, n);
            check({tag, " timeouts"}, n_to, 0);
            check({tag, " avg_pulses"}, n_avg, (exp_avg >= 0) ? 1 : 0);
            if (exp_avg >= 0) begin
                check({tag, " avg_value"}, avg_val, exp_avg);
                check({tag, " avg_time"}, avg_at, lag_at);
            end
            check({tag, " busy_end"}, busy_last, d + h + 3);
        end else begin
            check({tag, " timeouts"}, n_to, 1);
            check({tag, " timeout_time"}, to_at, TMO * CLKS);
            check({tag, " lag_pulses"}, n_lag, 0);
            check({tag, " avg_pulses"}, n_avg, 0);
            check({tag, " lag_held"}, int'(lag_value), model_last);
            check({tag, " busy_end"}, busy_last, TMO * CLKS);
        end
        check({tag, " sample_count"}, int'(sample_count), model_count);
        $display("sample %s d=%0d h=%0d lag=%0d timeouts=%0d avg=%0d count=%0d",
                 tag, d, h, lag_val, n_to, avg_val, sample_count);
    endtask

    task automatic check_minmax(input string tag);
`ifdef LAG_MINMAX_EN
        check({tag, " lag_min"}, int'(lag_min), model_min);
        check({tag, " lag_max"}, int'(lag_max), model_max);
`else
        check({tag, " lag_min"}, int'(lag_min), 0);
        check({tag, " lag_max"}, int'(lag_max), 0);
`endif
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " lag_valid"}, int'(lag_valid), 0);
        check({tag, " lag_value"}, int'(lag_value), 0);
        check({tag, " timeout"}, int'(timeout), 0);
        check({tag, " avg_valid"}, int'(avg_valid), 0);
        check({tag, " avg_value"}, int'(avg_value), 0);
        check({tag, " sample_count"}, int'(sample_count), 0);
        check_minmax(tag);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int n_lag, lag_at, lag_val, n_to, to_at, n_avg, avg_at, avg_val, busy_last, dummy;
        int pulses;

        vecs[0] = '{d: 36,  h: 10, exp_lag: 10, exp_avg: -1};
        vecs[1] = '{d: 40,  h: 7,  exp_lag: 11, exp_avg: -1};
        vecs[2] = '{d: 44,  h: 12, exp_lag: 12, exp_avg: -1};
        vecs[3] = '{d: 52,  h: 6,  exp_lag: 14, exp_avg: 11};
        vecs[4] = '{d: 200, h: 20, exp_lag: 51, exp_avg: -1};

        reset_n = 1'b0;
        starttrigger = 1'b0;
        sensor = 1'b0;
        model_reset();
        repeat (4) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check_cleared("reset");
        @(posedge clock); #1;

        // Averaging block and the 200-cycle example
        for (int i = 0; i < 5; i++) begin
            do_sample(vecs[i].d, vecs[i].h, 0, n_lag, lag_at, lag_val, n_to, to_at,
                      n_avg, avg_at, avg_val, busy_last);
            model_push(vecs[i].exp_lag, dummy);
            check($sformatf("vec%0d lag_pulses", i), n_lag, 1);
            check($sformatf("vec%0d lag_value", i), lag_val, vecs[i].exp_lag);
            check($sformatf("vec%0d timeouts", i), n_to, 0);
            check($sformatf("vec%0d avg_pulses", i), n_avg, (vecs[i].exp_avg >= 0) ? 1 : 0);
            if (vecs[i].exp_avg >= 0) begin
                check($sformatf("vec%0d avg_value", i), avg_val, vecs[i].exp_avg);
                check($sformatf("vec%0d avg_time", i), avg_at, lag_at);
            end
            check($sformatf("vec%0d busy_end", i), busy_last, vecs[i].d + vecs[i].h + 3);
            check($sformatf("vec%0d sample_count", i), int'(sample_count), i + 1);
            $display("vec%0d d=%0d lag=%0d avg=%0d busy_end=%0d",
                     i, vecs[i].d, lag_val, avg_val, busy_last);
        end

        run_checked("timeout", 0, 0, 0);
        run_checked("glitch", 80, 10, 10);
        check_minmax("after_glitch");

        // Reset held for 3 cycles in the middle of a measurement
        starttrigger = 1'b1;
        @(posedge clock); #1;
        starttrigger = 1'b0;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            reset_n = (k >= 50 && k < 53) ? 1'b0 : 1'b1;
            if (k == 40) check("mid_busy", int'(busy), 1);
            @(negedge clock);
            if (lag_valid || timeout || avg_valid) pulses++;
            @(posedge clock); #1;
        end
        reset_n = 1'b1;
        model_reset();
        check("mid_reset pulses", pulses, 0);
        @(negedge clock);
        check_cleared("mid_reset");
        $display("mid-measurement reset pulses=%0d busy=%0d", pulses, busy);
        @(posedge clock); #1;

        run_checked("post30", 116, 9, 0);
        run_checked("post20", 76, 9, 0);
        run_checked("post40", 156, 9, 0);
        check_minmax("minmax");

        for (int i = 0; i < 16; i++) begin
            int d, h, g;
            d = $urandom_range(1, 380);
            h = $urandom_range(5, 30);
            g = ($urandom_range(0, 1) == 1) ? $urandom_range(6, 15) : 0;
            run_checked($sformatf("rand%0d", i), d, h, g);
        end
        check_minmax("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
